fruit_region_stats: RTL and testbench
=====================================

// Module: fruit_region_stats
// PURPOSE
//  Per-frame statistics on the 1-bit fruit mask from the YCbCr threshold stage (mask=1: pixel outside background window, i.e. object).
//  Tracks bounding box (x/y min/max) and foreground pixel count over each frame; latches results at frame end for classifier/overlay logic.
//  Sits directly downstream of the threshold stage and consumes its registered mask/hsync/vsync/de, which arrive already aligned.
// PARAMETERS
//  H_BITS    11    column counter width (max 2047 px/line)
//  V_BITS    11    row counter width (max 2047 lines)
//  CNT_BITS  22    foreground pixel counter width
//  MIN_PIX   256   minimum foreground count for o_found=1 (noise reject)
//  VS_POL    1     vsync active level (1=active-high)
// PORTS
//  pixelclk     in   1         pixel clock
//  reset_n      in   1         asynchronous, active-low reset
//  i_mask       in   1         foreground flag, valid when i_de=1
//  i_hsync      in   1         line sync (passed through only)
//  i_vsync      in   1         frame sync, polarity per VS_POL
//  i_de         in   1         active video
//  o_x_min      out  H_BITS    latched bbox left column
//  o_x_max      out  H_BITS    latched bbox right column
//  o_y_min      out  V_BITS    latched bbox top row
//  o_y_max      out  V_BITS    latched bbox bottom row
//  o_pix_cnt    out  CNT_BITS  latched foreground count (saturating)
//  o_found      out  1         latched: o_pix_cnt >= MIN_PIX
//  o_stat_vld   out  1         1-cycle pulse when latched outputs update
//  o_hsync/o_vsync/o_de/o_mask  out 1   inputs delayed by exactly 1 cycle
// BEHAVIOUR
//  - Reset: all outputs 0. Internal x/y counters 0, accumulators cleared (min=all-ones, max=0, cnt=0). FSM -> WAIT_SOF.
//  - Frame boundary = active edge of vsync (rising if VS_POL=1), detected with one input register.
//  - Column x: 0 at first de=1 pixel of line, +1 per de=1 cycle, cleared on de falling edge.
//  - Row y: +1 on each de falling edge, cleared at frame boundary; first active line is y=0.
//  - FSM:
//    WAIT_SOF: ignore data; on frame boundary -> ACCUM (clear accumulators). Discards the partial frame after reset.
//    ACCUM: each de=1 && mask=1 cycle updates min/max with (x,y); cnt+=1, saturating at 2^CNT_BITS-1.
//           On frame boundary -> LATCH.
//    LATCH: single cycle. Copy accumulators to outputs; o_stat_vld=1; clear accumulators, y=0 -> ACCUM.
//  - Sample on a boundary cycle: if de=1 && mask=1 coincides with the boundary edge, the pixel belongs to the NEW frame (boundary wins).
//    The same rule applies to a pixel on the LATCH cycle: it is counted into the cleared accumulators.
//  - Empty frame (cnt=0): x_min/x_max/y_min/y_max latch as 0; o_found=0; o_stat_vld still pulses.
//  - Latch latency: o_stat_vld asserts exactly 2 cycles after the vsync edge appears on i_vsync. Outputs hold until the next latch.
//  - Counter wrap: x/y saturate at all-ones (no wrap); oversized lines must not corrupt the min/max of earlier pixels.
//  - reset_n mid-frame: immediate clear, back to WAIT_SOF; the first o_stat_vld follows the second full vsync edge after release.
// STRUCTURE
//  - Shared package/header: FSM state encodings (WAIT_SOF, ACCUM, LATCH); default H_BITS/V_BITS shared with the timing generator.
//  - Sub-module: fruit_pos_counter (de/vsync edge detect + x/y counters), reusable by the overlay stage; everything else stays inline.
// TESTING
//  1. Reset, then 2 frames of 64x48 with de, mask=0 -> first o_stat_vld after 2nd vsync edge; pix_cnt=0, found=0, bbox=0.
//  2. mask=1 in rect x=10..29, y=5..24 (400 px), MIN_PIX=256 -> x_min=10 x_max=29 y_min=5 y_max=24 pix_cnt=400 found=1.
//  3. Single pixel mask at (63,47) -> bbox min=max=(63,47), pix_cnt=1, found=0.
//  4. mask=1 pixel on the vsync-edge cycle -> counted in next frame only; previous frame's latched count excludes it.
//  5. reset_n low for 3 cycles mid-frame -> outputs 0 immediately; partial frame discarded; next full frame reports correct stats.
//  6. CNT_BITS=4, 20 fg px -> pix_cnt=15 (saturated), found per MIN_PIX; o_de/o_mask exactly 1-cycle delayed throughout.

Source files
------------

// File: rtl/fruit_region_stats_pkg.sv
// Shared definitions for the fruit region statistics block and the video
// timing generator: default counter widths and the statistics FSM states.
package fruit_region_stats_pkg;

    localparam int H_BITS_DEF = 11;
    localparam int V_BITS_DEF = 11;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_LATCH    = 2'd2
    } state_t;

endpackage

// File: rtl/fruit_pos_counter.sv
// Pixel position tracker: vsync active-edge detect plus column/row counters.
// Ports:
//   pixelclk, reset_n    clock, async active-low reset
//   i_de, i_vsync        active video, frame sync (polarity VS_POL)
//   i_clr_y              extra row clear request
//   o_x, o_y             coordinates of the pixel currently on the inputs
//   o_sof                1 on the cycle the vsync active edge is on i_vsync
module fruit_pos_counter
    import fruit_region_stats_pkg::*;
#(
    parameter int H_BITS = H_BITS_DEF,
    parameter int V_BITS = V_BITS_DEF,
    parameter bit VS_POL = 1'b1
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    input  logic              i_de,
    input  logic              i_vsync,
    input  logic              i_clr_y,
    output logic [H_BITS-1:0] o_x,
    output logic [V_BITS-1:0] o_y,
    output logic              o_sof
);

    logic              r_vs_act_d;
    logic              r_de_d;
    logic [H_BITS-1:0] r_x;
    logic [V_BITS-1:0] r_y;
    logic              w_vs_act;
    logic              w_de_fall;

    assign w_vs_act  = (i_vsync == VS_POL);
    assign o_sof     = w_vs_act & ~r_vs_act_d;
    assign w_de_fall = ~i_de & r_de_d;

    // The boundary pixel already belongs to the new frame, so its row is 0.
    assign o_x = r_x;
    assign o_y = o_sof ? '0 : r_y;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_act_d <= 1'b0;
            r_de_d     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_vs_act_d <= w_vs_act;
            r_de_d     <= i_de;
            // Saturate instead of wrapping so an oversized line can never
            // pull x_min back towards 0.
            if (i_de) begin
                if (r_x != '1) r_x <= r_x + 1'b1;
            end else begin
                r_x <= '0;
            end
            if (o_sof || i_clr_y) begin
                r_y <= '0;
            end else if (w_de_fall && (r_y != '1)) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fruit_region_stats.sv
// Per-frame bounding box and foreground count of the fruit mask, latched at
// each frame boundary for the classifier/overlay stages.
// Ports:
//   pixelclk, reset_n              clock, async active-low reset
//   i_mask/i_hsync/i_vsync/i_de    registered outputs of the threshold stage
//   o_x_min/o_x_max/o_y_min/o_y_max  latched bounding box (0 when empty)
//   o_pix_cnt, o_found             latched saturating count, count >= MIN_PIX
//   o_stat_vld                     1-cycle pulse when the latched set updates
//   o_hsync/o_vsync/o_de/o_mask    inputs delayed by one cycle
//
// state       | meaning
// ST_WAIT_SOF | after reset, discard data until the first frame boundary
// ST_ACCUM    | accumulate bbox/count of the current frame
// ST_LATCH    | publish the frame captured at the boundary, pulse o_stat_vld
module fruit_region_stats
    import fruit_region_stats_pkg::*;
#(
    parameter int H_BITS   = H_BITS_DEF,
    parameter int V_BITS   = V_BITS_DEF,
    parameter int CNT_BITS = 22,
    parameter int MIN_PIX  = 256,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                pixelclk,
    input  logic                reset_n,
    input  logic                i_mask,
    input  logic                i_hsync,
    input  logic                i_vsync,
    input  logic                i_de,
    output logic [H_BITS-1:0]   o_x_min,
    output logic [H_BITS-1:0]   o_x_max,
    output logic [V_BITS-1:0]   o_y_min,
    output logic [V_BITS-1:0]   o_y_max,
    output logic [CNT_BITS-1:0] o_pix_cnt,
    output logic                o_found,
    output logic                o_stat_vld,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_de,
    output logic                o_mask
);

    state_t r_state, w_state_nxt;

    logic [H_BITS-1:0]   w_x;
    logic [V_BITS-1:0]   w_y;
    logic                w_sof;
    logic                w_pix;
    logic                w_latch;

    logic [H_BITS-1:0]   r_acc_xmin, r_acc_xmax, r_snap_xmin, r_snap_xmax;
    logic [V_BITS-1:0]   r_acc_ymin, r_acc_ymax, r_snap_ymin, r_snap_ymax;
    logic [CNT_BITS-1:0] r_acc_cnt, r_snap_cnt;

    logic [H_BITS-1:0]   w_base_xmin, w_base_xmax, w_nxt_xmin, w_nxt_xmax;
    logic [V_BITS-1:0]   w_base_ymin, w_base_ymax, w_nxt_ymin, w_nxt_ymax;
    logic [CNT_BITS-1:0] w_base_cnt, w_nxt_cnt;

    fruit_pos_counter #(
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .VS_POL (VS_POL)
    ) u_pos (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .i_de     (i_de),
        .i_vsync  (i_vsync),
        .i_clr_y  (w_latch),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_sof    (w_sof)
    );

    assign w_pix   = i_de & i_mask;
    assign w_latch = (r_state == ST_LATCH);

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_WAIT_SOF;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_SOF: if (w_sof) w_state_nxt = ST_ACCUM;
            ST_ACCUM:    if (w_sof) w_state_nxt = ST_LATCH;
            ST_LATCH:    w_state_nxt = ST_ACCUM;
            default:     w_state_nxt = ST_WAIT_SOF;
        endcase
    end

    // The accumulators restart on the boundary cycle itself so that a pixel
    // coinciding with the edge lands in the new frame; the finished frame is
    // parked in the snapshot bank and published on the following LATCH cycle.
    always_comb begin
        w_base_xmin = w_sof ? '1 : r_acc_xmin;
        w_base_xmax = w_sof ? '0 : r_acc_xmax;
        w_base_ymin = w_sof ? '1 : r_acc_ymin;
        w_base_ymax = w_sof ? '0 : r_acc_ymax;
        w_base_cnt  = w_sof ? '0 : r_acc_cnt;
        w_nxt_xmin  = w_base_xmin;
        w_nxt_xmax  = w_base_xmax;
        w_nxt_ymin  = w_base_ymin;
        w_nxt_ymax  = w_base_ymax;
        w_nxt_cnt   = w_base_cnt;
        if (w_pix) begin
            if (w_x < w_base_xmin) w_nxt_xmin = w_x;
            if (w_x > w_base_xmax) w_nxt_xmax = w_x;
            if (w_y < w_base_ymin) w_nxt_ymin = w_y;
            if (w_y > w_base_ymax) w_nxt_ymax = w_y;
            if (w_base_cnt != '1)  w_nxt_cnt  = w_base_cnt + 1'b1;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_xmin  <= '1;
            r_acc_xmax  <= '0;
            r_acc_ymin  <= '1;
            r_acc_ymax  <= '0;
            r_acc_cnt   <= '0;
            r_snap_xmin <= '0;
            r_snap_xmax <= '0;
            r_snap_ymin <= '0;
            r_snap_ymax <= '0;
            r_snap_cnt  <= '0;
            o_x_min     <= '0;
            o_x_max     <= '0;
            o_y_min     <= '0;
            o_y_max     <= '0;
            o_pix_cnt   <= '0;
            o_found     <= 1'b0;
            o_stat_vld  <= 1'b0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_de        <= 1'b0;
            o_mask      <= 1'b0;
        end else begin
            o_hsync    <= i_hsync;
            o_vsync    <= i_vsync;
            o_de       <= i_de;
            o_mask     <= i_mask;
            o_stat_vld <= w_latch;
            if ((r_state != ST_WAIT_SOF) || w_sof) begin
                r_acc_xmin <= w_nxt_xmin;
                r_acc_xmax <= w_nxt_xmax;
                r_acc_ymin <= w_nxt_ymin;
                r_acc_ymax <= w_nxt_ymax;
                r_acc_cnt  <= w_nxt_cnt;
            end
            if ((r_state == ST_ACCUM) && w_sof) begin
                r_snap_xmin <= r_acc_xmin;
                r_snap_xmax <= r_acc_xmax;
                r_snap_ymin <= r_acc_ymin;
                r_snap_ymax <= r_acc_ymax;
                r_snap_cnt  <= r_acc_cnt;
            end
            if (w_latch) begin
                // An empty frame still holds min = all-ones; report zeros.
                o_x_min   <= (r_snap_cnt == '0) ? '0 : r_snap_xmin;
                o_x_max   <= r_snap_xmax;
                o_y_min   <= (r_snap_cnt == '0) ? '0 : r_snap_ymin;
                o_y_max   <= r_snap_ymax;
                o_pix_cnt <= r_snap_cnt;
                o_found   <= (32'(r_snap_cnt) >= 32'(MIN_PIX));
            end
        end
    end

endmodule

// File: tb/tb_fruit_region_stats.sv
module tb_fruit_region_stats;

    logic pixelclk = 1'b0;
    logic reset_n  = 1'b0;
    logic i_mask = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;

    logic [10:0] o_x_min, o_x_max, o_y_min, o_y_max;
    logic [21:0] o_pix_cnt;
    logic        o_found, o_stat_vld, o_hsync, o_vsync, o_de, o_mask;

    logic [10:0] s_x_min, s_x_max, s_y_min, s_y_max;
    logic [3:0]  s_pix_cnt;
    logic        s_found, s_stat_vld, s_hsync, s_vsync, s_de, s_mask;

    always #5 pixelclk = ~pixelclk;

    fruit_region_stats u_dut (
        .pixelclk (pixelclk), .reset_n (reset_n),
        .i_mask (i_mask), .i_hsync (i_hsync), .i_vsync (i_vsync), .i_de (i_de),
        .o_x_min (o_x_min), .o_x_max (o_x_max), .o_y_min (o_y_min), .o_y_max (o_y_max),
        .o_pix_cnt (o_pix_cnt), .o_found (o_found), .o_stat_vld (o_stat_vld),
        .o_hsync (o_hsync), .o_vsync (o_vsync), .o_de (o_de), .o_mask (o_mask)
    );

    fruit_region_stats #(.CNT_BITS(4), .MIN_PIX(8)) u_sat (
        .pixelclk (pixelclk), .reset_n (reset_n),
        .i_mask (i_mask), .i_hsync (i_hsync), .i_vsync (i_vsync), .i_de (i_de),
        .o_x_min (s_x_min), .o_x_max (s_x_max), .o_y_min (s_y_min), .o_y_max (s_y_max),
        .o_pix_cnt (s_pix_cnt), .o_found (s_found), .o_stat_vld (s_stat_vld),
        .o_hsync (s_hsync), .o_vsync (s_vsync), .o_de (s_de), .o_mask (s_mask)
    );

    typedef struct {
        int due;
        int xmin, xmax, ymin, ymax, cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   edges = 0;
    bit   last_vs = 1'b0;
    int   cxmin, cxmax, cymin, cymax, ccnt;
    bit   fm [48][64];

    // one-cycle delayed view of the inputs for the pass-through check
    logic d_rst = 1'b0, d_de = 1'b0, d_mask = 1'b0, d_hs = 1'b0, d_vs = 1'b0;

    always @(posedge pixelclk) begin
        cyc    <= cyc + 1;
        d_rst  <= reset_n;
        d_de   <= i_de;
        d_mask <= i_mask;
        d_hs   <= i_hsync;
        d_vs   <= i_vsync;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge pixelclk) begin
        bit   exp_vld;
        bit   live;
        int   sc;
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_vld = (q.size() > 0) && (q[0].due == cyc);
        chk("stat_vld", 32'(o_stat_vld), 32'(exp_vld));
        chk("stat_vld_sat", 32'(s_stat_vld), 32'(exp_vld));
        if (exp_vld) begin
            e  = q.pop_front();
            sc = (e.cnt > 15) ? 15 : e.cnt;
            chk("x_min", 32'(o_x_min), e.xmin);
            chk("x_max", 32'(o_x_max), e.xmax);
            chk("y_min", 32'(o_y_min), e.ymin);
            chk("y_max", 32'(o_y_max), e.ymax);
            chk("pix_cnt", 32'(o_pix_cnt), e.cnt);
            chk("found", 32'(o_found), 32'(e.cnt >= 256));
            chk("x_min_sat", 32'(s_x_min), e.xmin);
            chk("x_max_sat", 32'(s_x_max), e.xmax);
            chk("y_min_sat", 32'(s_y_min), e.ymin);
            chk("y_max_sat", 32'(s_y_max), e.ymax);
            chk("pix_cnt_sat", 32'(s_pix_cnt), sc);
            chk("found_sat", 32'(s_found), 32'(sc >= 8));
        end
        live = reset_n && d_rst;
        chk("o_de_dly", 32'(o_de), 32'(live & d_de));
        chk("o_mask_dly", 32'(o_mask), 32'(live & d_mask));
        chk("o_hsync_dly", 32'(o_hsync), 32'(live & d_hs));
        chk("o_vsync_dly", 32'(o_vsync), 32'(live & d_vs));
        chk("s_de_dly", 32'(s_de), 32'(live & d_de));
        chk("s_mask_dly", 32'(s_mask), 32'(live & d_mask));
        chk("s_hsync_dly", 32'(s_hsync), 32'(live & d_hs));
        chk("s_vsync_dly", 32'(s_vsync), 32'(live & d_vs));
    end

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    task automatic clear_cur();
        cxmin = 1 << 30; cxmax = -1; cymin = 1 << 30; cymax = -1; ccnt = 0;
    endtask

    task automatic push_cur(input int due);
        exp_t e;
        e.due = due;
        e.cnt = ccnt;
        if (ccnt == 0) begin
            e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
        end else begin
            e.xmin = cxmin; e.xmax = cxmax; e.ymin = cymin; e.ymax = cymax;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge pixelclk);
        #1;
    endtask

    // Drives one cycle; a frame boundary closes the frame collected so far
    // (reported 2 cycles later) before the boundary pixel is counted.
    task automatic drive(input bit vs, input bit hs, input bit de, input bit mk,
                         input int x, input int y);
        i_vsync = vs; i_hsync = hs; i_de = de; i_mask = mk;
        if (vs && !last_vs) begin
            if (edges > 0) push_cur(cyc + 2);
            clear_cur();
            edges++;
        end
        last_vs = vs;
        if (de && mk && edges > 0) begin
            if (x < cxmin) cxmin = x;
            if (x > cxmax) cxmax = x;
            if (y < cymin) cymin = y;
            if (y > cymax) cymax = y;
            ccnt++;
        end
        step();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b1; i_mask = 1'b1;
        q.delete();
        edges = 0;
        last_vs = 1'b0;
        clear_cur();
        #1;
        chk("rst_x_min", 32'(o_x_min), 0);
        chk("rst_x_max", 32'(o_x_max), 0);
        chk("rst_y_min", 32'(o_y_min), 0);
        chk("rst_y_max", 32'(o_y_max), 0);
        chk("rst_pix_cnt", 32'(o_pix_cnt), 0);
        chk("rst_found", 32'(o_found), 0);
        chk("rst_stat_vld", 32'(o_stat_vld), 0);
        repeat (n) step();
        reset_n = 1'b1;
        i_de = 1'b0; i_mask = 1'b0;
    endtask

    task automatic clear_fm();
        for (int r = 0; r < 48; r++)
            for (int c = 0; c < 64; c++) fm[r][c] = 1'b0;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int r = y0; r <= y1; r++)
            for (int c = x0; c <= x1; c++) fm[r][c] = 1'b1;
    endtask

    // Garbage lines with no vsync edge (data the DUT must discard).
    task automatic send_lines(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) drive(1'b0, 1'b0, 1'b1, 1'b1, c, r);
            for (int k = 0; k < 6; k++) drive(1'b0, k < 2, 1'b0, rbit(), 0, 0);
        end
    endtask

    task automatic send_frame(input int w, input int h, input bit aligned, input int abort_row);
        if (!aligned) begin
            repeat (4) drive(1'b1, 1'b0, 1'b0, rbit(), 0, 0);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, rbit(), 0, 0);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == abort_row && c == w / 2) begin
                    do_reset(3);
                    return;
                end
                drive(aligned && r == 0 && c < 4, 1'b0, 1'b1, fm[r][c], c, r);
            end
            for (int k = 0; k < 6; k++) drive(1'b0, k < 2, 1'b0, rbit(), 0, 0);
        end
    endtask

    task automatic send_vs();
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic rand_frame(input bit aligned, input int abort);
        int w, h, x0, x1, y0, y1;
        w  = $urandom_range(64, 8);
        h  = $urandom_range(48, 4);
        x0 = $urandom_range(w - 1, 0);
        x1 = $urandom_range(w - 1, x0);
        y0 = $urandom_range(h - 1, 0);
        y1 = $urandom_range(h - 1, y0);
        clear_fm();
        set_rect(x0, x1, y0, y1);
        repeat (5) fm[$urandom_range(h - 1, 0)][$urandom_range(w - 1, 0)] = 1'b1;
        if (aligned) fm[0][0] = 1'b1;
        send_frame(w, h, aligned, (abort >= 0) ? h / 2 : -1);
    endtask

    initial begin
        clear_cur();
        do_reset(3);
        send_lines(16, 3);

        // empty frames; first report only after the second edge
        clear_fm();
        send_frame(64, 48, 1'b0, -1);
        send_frame(64, 48, 1'b0, -1);

        clear_fm();
        set_rect(10, 29, 5, 24);
        send_frame(64, 48, 1'b0, -1);

        clear_fm();
        fm[47][63] = 1'b1;
        send_frame(64, 48, 1'b0, -1);

        // just below and exactly at the noise-reject threshold
        clear_fm();
        set_rect(0, 14, 0, 16);
        send_frame(40, 20, 1'b0, -1);
        clear_fm();
        set_rect(40, 55, 20, 35);
        send_frame(64, 40, 1'b0, -1);

        // 20 px: narrow instance saturates at 15
        clear_fm();
        set_rect(30, 33, 2, 6);
        send_frame(40, 10, 1'b0, -1);

        // vsync edge on the first pixel of a frame, which is foreground
        rand_frame(1'b1, -1);
        repeat (4) rand_frame(1'b0, -1);
        rand_frame(1'b1, -1);

        // reset in the middle of a frame
        rand_frame(1'b0, 1);
        send_lines(20, 2);
        clear_fm();
        set_rect(3, 12, 1, 7);
        send_frame(32, 12, 1'b0, -1);
        rand_frame(1'b0, -1);
        send_vs();

        repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("all_reports_seen", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
